// File: rtl/et_peak_sensing_win.sv
`default_nettype none
// ============================================================================
// Module      : et_peak_sensing_win
// Description : Streaming Et local-maximum detector over a +/-HALF_WIN window.
//               Flags a centre sample above et_thre that is strictly greater
//               than every older neighbour and >= every newer neighbour.
//               Start-up fill masking and a programmable dead time are
//               applied. The output is the delayed Et with the flag as MSB.
//               Optional macro ET_PEAK_CNT_EN adds a saturating flagged-peak
//               counter (peak_cnt) with a synchronous clear (cnt_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module et_peak_sensing_win #(
    parameter int ET_WIDTH = 16,
    parameter int HALF_WIN = 2,
    parameter int DEAD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ET_WIDTH-1:0] in_et,
    input  logic [ET_WIDTH-1:0] et_thre,
    input  logic [DEAD_W-1:0]   dead_time,
`ifdef ET_PEAK_CNT_EN
    input  logic                cnt_clr,
    output logic [15:0]         peak_cnt,
`endif
    output logic [ET_WIDTH:0]   out_et
);

    localparam int c_WIN      = 2 * HALF_WIN + 1;
    localparam int c_FILL_W   = $clog2(c_WIN + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(c_WIN);

    logic [ET_WIDTH-1:0] r_tap [0:c_WIN-1];
    logic [c_FILL_W-1:0] r_fill;
    logic [DEAD_W-1:0]   r_dcnt;
    logic [ET_WIDTH:0]   r_out_et;

    logic [ET_WIDTH-1:0] w_c;
    logic                w_cand;
    logic                w_filled;
    logic                w_flag;

    assign w_c      = r_tap[HALF_WIN];
    assign w_filled = (r_fill == c_FILL_MAX);
    assign w_flag   = w_cand & w_filled & (r_dcnt == '0);
    assign out_et   = r_out_et;

    // Shift register: r_tap[k] holds the sample captured k edges ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < c_WIN; k++) r_tap[k] <= '0;
        end else begin
            r_tap[0] <= in_et;
            for (int k = 1; k < c_WIN; k++) r_tap[k] <= r_tap[k-1];
        end
    end

    // Window maximum test; the strict compare on the older side makes a
    // plateau flag only its first (oldest) sample.
    always_comb begin
        w_cand = (w_c > et_thre);
        for (int k = 0; k < HALF_WIN; k++) begin
            if (!(w_c >= r_tap[k]))              w_cand = 1'b0;
            if (!(w_c >  r_tap[HALF_WIN + 1 + k])) w_cand = 1'b0;
        end
    end

    // Count captured samples until the whole window holds post-reset data.
    always_ff @(posedge clk) begin
        if (rst)                      r_fill <= '0;
        else if (r_fill != c_FILL_MAX) r_fill <= r_fill + 1'b1;
    end

    // Dead-time counter, loaded only when a peak is flagged.
    always_ff @(posedge clk) begin
        if (rst)                r_dcnt <= '0;
        else if (w_flag)        r_dcnt <= dead_time;
        else if (r_dcnt != '0)  r_dcnt <= r_dcnt - 1'b1;
    end

    // Registered output: delayed centre sample with the peak flag on top.
    always_ff @(posedge clk) begin
        if (rst) r_out_et <= '0;
        else     r_out_et <= {w_flag, w_c};
    end

`ifdef ET_PEAK_CNT_EN
    logic [15:0] r_peak_cnt;

    assign peak_cnt = r_peak_cnt;

    // Saturating count of flagged peaks; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst)                                  r_peak_cnt <= '0;
        else if (cnt_clr)                         r_peak_cnt <= '0;
        else if (w_flag && (r_peak_cnt != 16'hFFFF)) r_peak_cnt <= r_peak_cnt + 16'd1;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_et_peak_sensing_win.sv
`default_nettype none
// ============================================================================
// Module      : tb_et_peak_sensing_win
// Description : Directed self-checking bench for et_peak_sensing_win with
//               HALF_WIN=2, ET_WIDTH=16, et_thre=10. Counter scenarios are
//               built only when ET_PEAK_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_et_peak_sensing_win;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_et;
    logic [15:0] et_thre;
    logic [7:0]  dead_time;
    logic [16:0] out_et;
`ifdef ET_PEAK_CNT_EN
    logic        cnt_clr;
    logic [15:0] peak_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] stim [0:39];
    logic [16:0] obs  [0:39];

    et_peak_sensing_win #(
        .ET_WIDTH (16),
        .HALF_WIN (2),
        .DEAD_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_et     (in_et),
        .et_thre   (et_thre),
        .dead_time (dead_time),
`ifdef ET_PEAK_CNT_EN
        .cnt_clr   (cnt_clr),
        .peak_cnt  (peak_cnt),
`endif
        .out_et    (out_et)
    );

    always #5 clk = ~clk;

    // One sample per edge; outputs are read 1 time unit after the edge.
    task automatic step(input logic [15:0] v);
        in_et = v;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 40; i++) stim[i] = 16'd0;
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            step(stim[i]);
            obs[i] = out_et;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(16'd0);
        step(16'd0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(16'd1234);
        step(16'd777);
        n_checks++;
        if (out_et !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_out: out_et=%h expected %h", out_et, 17'd0);
        end
`ifdef ET_PEAK_CNT_EN
        n_checks++;
        if (peak_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: peak_cnt=%h expected %h", peak_cnt, 16'd0);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [16:0] exp [0:7];
        do_reset();
        clear_stim();
        stim[2] = 16'd5; stim[3] = 16'd20; stim[4] = 16'd5;
        exp = '{17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd5, {1'b1, 16'd20}, 17'd5};
        play(8);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL basic step %0d: out_et=%h expected %h", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_fill();
        logic [16:0] exp [0:11];
        do_reset();
        clear_stim();
        stim[0] = 16'd5; stim[1] = 16'd20; stim[2] = 16'd5;
        stim[7] = 16'd5; stim[8] = 16'd20; stim[9] = 16'd5;
        exp = '{17'd0, 17'd0, 17'd0, 17'd5, 17'd20, 17'd5,
                17'd0, 17'd0, 17'd0, 17'd0, 17'd5, {1'b1, 16'd20}};
        play(12);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (obs[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL fill step %0d: out_et=%h expected %h", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_plateau_thresh();
        logic [39:0] flags;
        logic [16:0] expv;
        int          j;
        do_reset();
        clear_stim();
        stim[7]  = 16'd30; stim[8] = 16'd30;
        stim[12] = 16'd10;
        flags = '0;
        flags[10] = 1'b1;
        play(16);
        for (int i = 0; i < 16; i++) begin
            j = i - 3;
            expv = {flags[i], (j < 0) ? 16'd0 : stim[j]};
            n_checks++;
            if (obs[i] !== expv) begin
                n_fail++;
                $display("FAIL plateau step %0d: out_et=%h expected %h", i, obs[i], expv);
            end
        end
    endtask

    task automatic test_dead_time();
        logic [39:0] flags;
        logic [16:0] expv;
        int          j;
        do_reset();
        clear_stim();
        dead_time = 8'd3;
        stim[7] = 16'd20; stim[10] = 16'd20; stim[15] = 16'd20; stim[19] = 16'd20;
        flags = '0;
        flags[10] = 1'b1;
        flags[18] = 1'b1;
        flags[22] = 1'b1;
        play(24);
        for (int i = 0; i < 24; i++) begin
            j = i - 3;
            expv = {flags[i], (j < 0) ? 16'd0 : stim[j]};
            n_checks++;
            if (obs[i] !== expv) begin
                n_fail++;
                $display("FAIL dead step %0d: out_et=%h expected %h", i, obs[i], expv);
            end
        end
        dead_time = 8'd0;
    endtask

    task automatic test_reset_mid();
        logic [16:0] expv;
        int          j;
        do_reset();
        clear_stim();
        stim[7] = 16'd5; stim[8] = 16'd40; stim[9] = 16'd5;
        play(11);
        n_checks++;
        if (obs[10] !== 17'd5) begin
            n_fail++;
            $display("FAIL rstmid_pre: out_et=%h expected %h", obs[10], 17'd5);
        end
        rst = 1'b1;
        step(16'd0);
        rst = 1'b0;
        n_checks++;
        if (out_et !== 17'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: out_et=%h expected %h", out_et, 17'd0);
        end
        clear_stim();
        stim[0] = 16'd5; stim[1] = 16'd40; stim[2] = 16'd5;
        play(8);
        for (int i = 0; i < 8; i++) begin
            j = i - 3;
            expv = {1'b0, (j < 0) ? 16'd0 : stim[j]};
            n_checks++;
            if (obs[i] !== expv) begin
                n_fail++;
                $display("FAIL rstmid step %0d: out_et=%h expected %h", i, obs[i], expv);
            end
        end
    endtask

`ifdef ET_PEAK_CNT_EN
    task automatic test_peak_cnt();
        do_reset();
        clear_stim();
        stim[7] = 16'd20; stim[11] = 16'd20; stim[15] = 16'd20;
        stim[23] = 16'd20; stim[31] = 16'd20;
        for (int i = 0; i < 36; i++) begin
            in_et   = stim[i];
            cnt_clr = (i == 26);
            if (i == 28) begin
                force dut.r_peak_cnt = 16'hFFFF;
                #1;
                release dut.r_peak_cnt;
            end
            @(posedge clk);
            #1;
            obs[i] = out_et;
            if (i == 19) begin
                n_checks++;
                if (peak_cnt !== 16'd3) begin
                    n_fail++;
                    $display("FAIL cnt_three: peak_cnt=%h expected %h", peak_cnt, 16'd3);
                end
            end
            if (i == 26) begin
                n_checks++;
                if (peak_cnt !== 16'd0 || out_et !== {1'b1, 16'd20}) begin
                    n_fail++;
                    $display("FAIL cnt_clr: peak_cnt=%h out_et=%h expected 0000 and %h",
                             peak_cnt, out_et, {1'b1, 16'd20});
                end
            end
            if (i == 34) begin
                n_checks++;
                if (peak_cnt !== 16'hFFFF || out_et !== {1'b1, 16'd20}) begin
                    n_fail++;
                    $display("FAIL cnt_sat: peak_cnt=%h out_et=%h expected ffff and %h",
                             peak_cnt, out_et, {1'b1, 16'd20});
                end
            end
        end
        cnt_clr = 1'b0;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_et     = 16'd0;
        et_thre   = 16'd10;
        dead_time = 8'd0;
`ifdef ET_PEAK_CNT_EN
        cnt_clr   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_fill();
        test_plateau_thresh();
        test_dead_time();
        test_reset_mid();
`ifdef ET_PEAK_CNT_EN
        test_peak_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
